// File: rtl/rand_burst_ctrl.sv
// ---------------------------------------------------------------------------
// rand_burst_ctrl
//
// Burst sequencer in front of the bit-serial 802.16 OFDM randomizer.
// A burst descriptor is accepted in IDLE. The 15-bit randomizer seed is built
// from BSID, DIUC and frame number and loaded with a one-cycle reload pulse.
// The MAC payload bytes are then serialized MSB-first. Pad bytes follow, up to
// the allocated burst size, and a one-cycle done pulse closes the burst.
//
// Ports
//   clk               system clock, all logic on posedge
//   reset             asynchronous, active-high
//   start_i           descriptor valid (accepted when start_i && start_ready_o)
//   start_ready_o     high only in IDLE
//   bsid_i            BSID LSBs            (sampled on start accept)
//   diuc_i            burst DIUC           (sampled on start accept)
//   frame_num_i       frame number LSBs    (sampled on start accept)
//   burst_len_i       payload bytes        (sampled on start accept)
//   alloc_len_i       allocated bytes      (sampled on start accept)
//   abort_i           synchronous abort of the current burst
//   in_byte_i         payload byte from MAC
//   in_byte_valid_i   payload byte valid
//   in_byte_ready_o   controller takes a byte this cycle
//   rnd_bits_o        serial bit to randomizer
//   rnd_valid_o       serial bit valid
//   rnd_iv_o          randomizer seed
//   rnd_reload_o      randomizer seed reload
//   busy_o            high in any state other than IDLE
//   done_o            one-cycle pulse at burst completion
// ---------------------------------------------------------------------------
module rand_burst_ctrl #(
  parameter int unsigned LEN_W    = 12,
  parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic             start_ready_o,
  input  logic [3:0]       bsid_i,
  input  logic [3:0]       diuc_i,
  input  logic [3:0]       frame_num_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [LEN_W-1:0] alloc_len_i,
  input  logic             abort_i,
  input  logic [7:0]       in_byte_i,
  input  logic             in_byte_valid_i,
  output logic             in_byte_ready_o,
  output logic             rnd_bits_o,
  output logic             rnd_valid_o,
  output logic [14:0]      rnd_iv_o,
  output logic             rnd_reload_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [LEN_W-1:0] burst_len_q, burst_len_d;
  logic [LEN_W-1:0] pad_len_q, pad_len_d;
  logic [LEN_W-1:0] bytes_taken_q, bytes_taken_d;
  logic [LEN_W-1:0] pads_sent_q, pads_sent_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [14:0]      iv_q, iv_d;
  logic             rnd_bits_q, rnd_bits_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic             rnd_reload_q, rnd_reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             more_bytes_s;
  logic             take_byte_s;
  logic             abort_s;

  // Seed layout expected by the randomizer: bsid | 11 | diuc | 1 | frame.
  function automatic logic [14:0] build_seed(input logic [3:0] bsid,
                                             input logic [3:0] diuc,
                                             input logic [3:0] frame);
    build_seed = {bsid, 2'b11, diuc, 1'b1, frame};
  endfunction

  // Pad count with alloc clamped up to the payload length.
  function automatic logic [LEN_W-1:0] pad_count(input logic [LEN_W-1:0] alloc,
                                                 input logic [LEN_W-1:0] blen);
    if (alloc > blen) begin
      pad_count = alloc - blen;
    end else begin
      pad_count = LEN_ZERO;
    end
  endfunction

  // bit_cnt_q counts bits still waiting in sr_q. When it is zero, the bit on
  // rnd_bits_o (if any) is the LSB, so a byte taken now streams gap-free.
  assign more_bytes_s    = (bytes_taken_q < burst_len_q);
  assign start_ready_o   = (state_q == S_IDLE);
  assign in_byte_ready_o = ((state_q == S_LOAD) ||
                            ((state_q == S_DATA) && (bit_cnt_q == 3'd0))) && more_bytes_s;
  assign take_byte_s     = in_byte_ready_o && in_byte_valid_i;
  assign abort_s         = abort_i && (state_q != S_IDLE);

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    burst_len_d   = burst_len_q;
    pad_len_d     = pad_len_q;
    bytes_taken_d = bytes_taken_q;
    pads_sent_d   = pads_sent_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    iv_d          = iv_q;
    rnd_bits_d    = 1'b0;
    rnd_valid_d   = 1'b0;
    done_d        = 1'b0;

    if (abort_s) begin
      // Drop the burst; any partially shifted byte is discarded.
      state_d   = S_IDLE;
      sr_d      = 8'h00;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d       = S_LOAD;
            burst_len_d   = burst_len_i;
            pad_len_d     = pad_count(alloc_len_i, burst_len_i);
            bytes_taken_d = LEN_ZERO;
            pads_sent_d   = LEN_ZERO;
            sr_d          = 8'h00;
            bit_cnt_d     = 3'd0;
            iv_d          = build_seed(bsid_i, diuc_i, frame_num_i);
          end else begin
            state_d = S_IDLE;
          end
        end

        // LOAD behaves like DATA with an empty shift register.
        S_LOAD, S_DATA: begin
          if (bit_cnt_q != 3'd0) begin
            rnd_bits_d  = sr_q[7];
            rnd_valid_d = 1'b1;
            sr_d        = {sr_q[6:0], 1'b0};
            bit_cnt_d   = bit_cnt_q - 3'd1;
            state_d     = S_DATA;
          end else if (take_byte_s) begin
            rnd_bits_d    = in_byte_i[7];
            rnd_valid_d   = 1'b1;
            sr_d          = {in_byte_i[6:0], 1'b0};
            bit_cnt_d     = 3'd7;
            bytes_taken_d = bytes_taken_q + LEN_ONE;
            state_d       = S_DATA;
          end else if (more_bytes_s) begin
            // Bubble: waiting for the MAC.
            state_d = S_DATA;
          end else if (pad_len_q != LEN_ZERO) begin
            // Payload done; first pad bit follows the last LSB directly.
            rnd_bits_d  = PAD_BYTE[7];
            rnd_valid_d = 1'b1;
            sr_d        = {PAD_BYTE[6:0], 1'b0};
            bit_cnt_d   = 3'd7;
            pads_sent_d = LEN_ONE;
            state_d     = S_PAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end

        S_PAD: begin
          if (bit_cnt_q != 3'd0) begin
            rnd_bits_d  = sr_q[7];
            rnd_valid_d = 1'b1;
            sr_d        = {sr_q[6:0], 1'b0};
            bit_cnt_d   = bit_cnt_q - 3'd1;
          end else if (pads_sent_q < pad_len_q) begin
            rnd_bits_d  = PAD_BYTE[7];
            rnd_valid_d = 1'b1;
            sr_d        = {PAD_BYTE[6:0], 1'b0};
            bit_cnt_d   = 3'd7;
            pads_sent_d = pads_sent_q + LEN_ONE;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d   = S_IDLE;
          sr_d      = 8'h00;
          bit_cnt_d = 3'd0;
        end
      endcase
    end

    rnd_reload_d = (state_d == S_LOAD);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      burst_len_q   <= LEN_ZERO;
      pad_len_q     <= LEN_ZERO;
      bytes_taken_q <= LEN_ZERO;
      pads_sent_q   <= LEN_ZERO;
      sr_q          <= 8'h00;
      bit_cnt_q     <= 3'd0;
      iv_q          <= 15'h0000;
      rnd_bits_q    <= 1'b0;
      rnd_valid_q   <= 1'b0;
      rnd_reload_q  <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_len_q   <= burst_len_d;
      pad_len_q     <= pad_len_d;
      bytes_taken_q <= bytes_taken_d;
      pads_sent_q   <= pads_sent_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      iv_q          <= iv_d;
      rnd_bits_q    <= rnd_bits_d;
      rnd_valid_q   <= rnd_valid_d;
      rnd_reload_q  <= rnd_reload_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign rnd_bits_o   = rnd_bits_q;
  assign rnd_valid_o  = rnd_valid_q;
  assign rnd_iv_o     = iv_q;
  assign rnd_reload_o = rnd_reload_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_rand_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rand_burst_ctrl
//
// Directed bench for rand_burst_ctrl. For each burst, the expected serial bit
// stream (payload MSB-first, then 0xFF pads) is queued when the descriptor is
// driven. The queue is popped on every rnd_valid cycle. Seed, reload, bubble
// count, done timing, abort and asynchronous reset are also checked.
// ---------------------------------------------------------------------------
module tb_rand_burst_ctrl;

  localparam logic [7:0] PAD = 8'hFF;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic        start_ready_o;
  logic [3:0]  bsid_i;
  logic [3:0]  diuc_i;
  logic [3:0]  frame_num_i;
  logic [11:0] burst_len_i;
  logic [11:0] alloc_len_i;
  logic        abort_i;
  logic [7:0]  in_byte_i;
  logic        in_byte_valid_i;
  logic        in_byte_ready_o;
  logic        rnd_bits_o;
  logic        rnd_valid_o;
  logic [14:0] rnd_iv_o;
  logic        rnd_reload_o;
  logic        busy_o;
  logic        done_o;

  int          n_cmp;
  int          n_err;
  logic        exp_q[$];
  logic [7:0]  data[$];

  rand_burst_ctrl #(.LEN_W(12), .PAD_BYTE(8'hFF)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .start_ready_o   (start_ready_o),
    .bsid_i          (bsid_i),
    .diuc_i          (diuc_i),
    .frame_num_i     (frame_num_i),
    .burst_len_i     (burst_len_i),
    .alloc_len_i     (alloc_len_i),
    .abort_i         (abort_i),
    .in_byte_i       (in_byte_i),
    .in_byte_valid_i (in_byte_valid_i),
    .in_byte_ready_o (in_byte_ready_o),
    .rnd_bits_o      (rnd_bits_o),
    .rnd_valid_o     (rnd_valid_o),
    .rnd_iv_o        (rnd_iv_o),
    .rnd_reload_o    (rnd_reload_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One burst. Cycle 0 = start accept. Optional gap before byte gap_idx,
  // abort after abort_at valid bits, async reset in cycle reset_at, and a
  // stray start in cycle inject_at (which must be ignored).
  task automatic run_burst(input logic [3:0] b, input logic [3:0] d, input logic [3:0] f,
                           input int blen, input int alen, input int gap_idx, input int gap_len,
                           input int abort_at, input int reset_at, input int inject_at,
                           input bit abort_with_start);
    logic [14:0] exp_iv;
    logic [7:0]  cur;
    logic        e;
    int          t_bytes, byte_idx, gap_left, cyc, nvalid, bubbles;
    bit          fin;

    exp_iv  = {b, 2'b11, d, 1'b1, f};
    t_bytes = (alen > blen) ? alen : blen;
    exp_q.delete();
    for (int i = 0; i < t_bytes; i++) begin
      cur = (i < blen) ? data[i] : PAD;
      for (int k = 7; k >= 0; k--) exp_q.push_back(cur[k]);
    end

    chk("start_ready_idle", {31'd0, start_ready_o}, 32'd1);
    start_i         = 1'b1;
    bsid_i          = b;
    diuc_i          = d;
    frame_num_i     = f;
    burst_len_i     = 12'(blen);
    alloc_len_i     = 12'(alen);
    abort_i         = abort_with_start;
    in_byte_valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    cyc     = 1;
    chk("reload",     {31'd0, rnd_reload_o}, 32'd1);
    chk("seed",       {17'd0, rnd_iv_o},     {17'd0, exp_iv});
    chk("load_valid", {31'd0, rnd_valid_o},  32'd0);
    chk("load_busy",  {31'd0, busy_o},       32'd1);

    byte_idx = 0; gap_left = gap_len; nvalid = 0; bubbles = 0; fin = 1'b0;
    while (!fin) begin
      // Observe this cycle's outputs.
      if (cyc > 3000) begin
        chk("timeout", 32'(cyc), 32'(8 * t_bytes + 2 + gap_len));
        fin = 1'b1;
      end else if (rnd_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("bit_count", 32'(nvalid + 1), 32'(8 * t_bytes));
        end else begin
          e = exp_q.pop_front();
          chk("bit", {31'd0, rnd_bits_o}, {31'd0, e});
        end
        nvalid++;
      end else if (done_o) begin
        chk("done_cycle", 32'(cyc),     32'(8 * t_bytes + 2 + gap_len));
        chk("bits_total", 32'(nvalid),  32'(8 * t_bytes));
        chk("bubbles",    32'(bubbles), 32'(gap_len));
        chk("iv_hold",    {17'd0, rnd_iv_o}, {17'd0, exp_iv});
        fin = 1'b1;
      end else if (cyc >= 2) begin
        bubbles++;
        chk("bubble_bit", {31'd0, rnd_bits_o}, 32'd0);
      end
      if (!fin && byte_idx >= blen) chk("ready_low", {31'd0, in_byte_ready_o}, 32'd0);

      if (!fin && abort_at >= 0 && nvalid == abort_at) begin
        abort_i = 1'b1;
        in_byte_valid_i = 1'b0;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_valid", {31'd0, rnd_valid_o},     32'd0);
        chk("abort_busy",  {31'd0, busy_o},          32'd0);
        chk("abort_ready", {31'd0, in_byte_ready_o}, 32'd0);
        chk("abort_sr",    {31'd0, start_ready_o},   32'd1);
        for (int i = 0; i < 3; i++) begin
          chk("abort_nodone", {31'd0, done_o}, 32'd0);
          @(negedge clk);
        end
        return;
      end

      if (!fin && reset_at >= 0 && cyc == reset_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_bits",   {31'd0, rnd_bits_o},      32'd0);
        chk("rst_valid",  {31'd0, rnd_valid_o},     32'd0);
        chk("rst_reload", {31'd0, rnd_reload_o},    32'd0);
        chk("rst_ready",  {31'd0, in_byte_ready_o}, 32'd0);
        chk("rst_done",   {31'd0, done_o},          32'd0);
        chk("rst_busy",   {31'd0, busy_o},          32'd0);
        chk("rst_iv",     {17'd0, rnd_iv_o},        32'd0);
        in_byte_valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_start_ready", {31'd0, start_ready_o}, 32'd1);
        return;
      end

      if (cyc == inject_at) begin
        start_i     = 1'b1;
        bsid_i      = ~b;
        burst_len_i = 12'd7;
        alloc_len_i = 12'd9;
      end else begin
        start_i = 1'b0;
      end

      if (byte_idx < blen && !(byte_idx == gap_idx && gap_left > 0)) begin
        in_byte_valid_i = 1'b1;
        in_byte_i       = data[byte_idx];
        if (in_byte_ready_o) byte_idx++;
      end else begin
        in_byte_valid_i = 1'b0;
        in_byte_i       = 8'h00;
        if (byte_idx == gap_idx && gap_left > 0 && in_byte_ready_o) gap_left--;
      end

      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end

    in_byte_valid_i = 1'b0;
    start_i         = 1'b0;
    @(negedge clk);
    chk("done_pulse",   {31'd0, done_o},        32'd0);
    chk("post_busy",    {31'd0, busy_o},        32'd0);
    chk("post_sready",  {31'd0, start_ready_o}, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start_i = 1'b0; bsid_i = 4'd0; diuc_i = 4'd0; frame_num_i = 4'd0;
    burst_len_i = 12'd0; alloc_len_i = 12'd0; abort_i = 1'b0;
    in_byte_i = 8'h00; in_byte_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_sready", {31'd0, start_ready_o},   32'd1);
    chk("reset_busy",   {31'd0, busy_o},          32'd0);
    chk("reset_valid",  {31'd0, rnd_valid_o},     32'd0);
    chk("reset_iv",     {17'd0, rnd_iv_o},        32'd0);
    chk("reset_ready",  {31'd0, in_byte_ready_o}, 32'd0);
    chk("reset_done",   {31'd0, done_o},          32'd0);

    // Basic two-byte burst, seed 0x0E11, stray start mid-burst ignored.
    data = '{8'hA5, 8'h3C};
    run_burst(4'd1, 4'd0, 4'd1, 2, 2, -1, 0, -1, -1, 6, 1'b0);
    chk("seed_0e11", {17'd0, rnd_iv_o}, 32'h0E11);

    // One zero byte followed by two pad bytes.
    data = '{8'h00};
    run_burst(4'd3, 4'd7, 4'd2, 1, 3, -1, 0, -1, -1, -1, 1'b0);

    // Three bytes with a 5-cycle MAC stall before the second one.
    data = '{8'h11, 8'h22, 8'h33};
    run_burst(4'd5, 4'd9, 4'd4, 3, 3, 1, 5, -1, -1, -1, 1'b0);

    // Empty burst: LOAD straight to DONE.
    data.delete();
    run_burst(4'd2, 4'd2, 4'd2, 0, 0, -1, 0, -1, -1, -1, 1'b0);

    // alloc_len below burst_len: clamped, no pad.
    data = '{8'h69, 8'hC3};
    run_burst(4'd8, 4'd1, 4'd15, 2, 1, -1, 0, -1, -1, -1, 1'b0);

    // Empty payload, pad only.
    data.delete();
    run_burst(4'd4, 4'd4, 4'd4, 0, 1, -1, 0, -1, -1, -1, 1'b0);

    // Abort after three bits, then a fresh burst with its own seed.
    data = '{8'hB7, 8'h48};
    run_burst(4'd6, 4'd3, 4'd9, 2, 2, -1, 0, 3, -1, -1, 1'b0);
    data = '{8'h5E};
    run_burst(4'd10, 4'd5, 4'd12, 1, 2, -1, 0, -1, -1, -1, 1'b0);

    // Asynchronous reset in the middle of the pad region.
    data = '{8'h00};
    run_burst(4'd7, 4'd6, 4'd3, 1, 3, -1, 0, -1, 14, -1, 1'b0);

    // Abort in IDLE does nothing.
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("idle_abort_busy",   {31'd0, busy_o},        32'd0);
    chk("idle_abort_sready", {31'd0, start_ready_o}, 32'd1);
    chk("idle_abort_done",   {31'd0, done_o},        32'd0);

    // Start and abort together in IDLE: the start wins.
    data = '{8'h5A};
    run_burst(4'd9, 4'd12, 4'd0, 1, 1, -1, 0, -1, -1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
